blk_assemble: RTL and testbench

Consumer of the memory-read datasets produced by the block-creation stage. Per dataset it takes 1–4 bytes from the word read out of thread memory, or synthesizes 0x80/zero padding or the length field. It packs them little-endian into 32-bit words, and emits each 64-byte block as 16 consecutive word writes, tagged with thread number and block op, into the MD5 core input buffer.

---
 rtl/blk_assemble_pkg.sv | 36 +++
 rtl/blk_assemble_byte_extract.sv | 51 +++++
 rtl/blk_assemble.sv | 212 +++++++++++++++++++++
 tb/tb_blk_assemble.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blk_assemble_pkg.sv
// Shared widths, types and helpers for the block assembler.
//   PROCB_TOTAL_MSB : MSB of the message byte total
//   BLK_OP_MSB      : MSB of the block op tag
//   BLK_WORDS       : 32-bit words per 64-byte block
//   BLK_BYTES       : bytes per block
package blk_assemble_pkg;

  localparam int unsigned PROCB_TOTAL_MSB = 15;
  localparam int unsigned BLK_OP_MSB      = 1;
  localparam int unsigned BLK_WORDS       = 16;
  localparam int unsigned BLK_BYTES       = 64;

  // Dataset source flags in priority order (mem wins over the synthesized sources).
  typedef struct packed {
    logic mem;
    logic add_total;
    logic add0x80pad;
    logic add0pad;
  } ds_kind_t;

  // Index of the highest set bit; 0 for an argument of 0.
  function automatic int msb(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) r = i;
    end
    return r;
  endfunction

  // More than one byte-producing source flagged in the same dataset.
  function automatic logic multi_src(input ds_kind_t k);
    return (k.mem & k.add_total) | (k.mem & k.add0x80pad) | (k.add_total & k.add0x80pad);
  endfunction

endpackage

// File: rtl/blk_assemble_byte_extract.sv
// Stage-1 byte formation: picks len bytes from the memory word at the given offset,
// or synthesizes the 0x80 pad byte, zero padding, or the bit-length field.
//   kind_i     : dataset source flags
//   len_i      : byte count 1..4 (bytes at or above len are forced to zero)
//   off_i      : byte offset within mem_dout_i
//   total_i    : message byte total
//   mem_dout_i : memory word read for this dataset
//   bytes_o    : byte k at bits [8k+7:8k]
module blk_assemble_byte_extract
  import blk_assemble_pkg::*;
(
  input  ds_kind_t                 kind_i,
  input  logic [2:0]               len_i,
  input  logic [1:0]               off_i,
  input  logic [PROCB_TOTAL_MSB:0] total_i,
  input  logic [31:0]              mem_dout_i,
  output logic [31:0]              bytes_o
);

  logic [31:0] raw;
  logic [31:0] mask;
  logic [31:0] total_bits;

  always_comb begin
    // Bit count = byte total * 8, zero-extended.
    total_bits = '0;
    total_bits[PROCB_TOTAL_MSB+3:0] = {total_i, 3'b000};

    if (kind_i.mem) begin
      raw = mem_dout_i >> {off_i, 3'b000};
    end else if (kind_i.add_total) begin
      raw = total_bits;
    end else if (kind_i.add0x80pad) begin
      raw = 32'h0000_0080;
    end else begin
      raw = '0;
    end

    // Zeroed upper bytes let the accumulator merge with a plain OR.
    case (len_i)
      3'd0:    mask = 32'h0000_0000;
      3'd1:    mask = 32'h0000_00ff;
      3'd2:    mask = 32'h0000_ffff;
      3'd3:    mask = 32'h00ff_ffff;
      default: mask = 32'hffff_ffff;
    endcase

    bytes_o = raw & mask;
  end

endmodule

// File: rtl/blk_assemble.sv
// Block assembler: packs dataset bytes little-endian into 32-bit words and writes each
// 64-byte block as 16 words into the MD5 core input buffer. Fixed latency of 2 cycles.
//   CLK, RST_N             : clock, asynchronous active-low reset
//   in_*                   : dataset (valid when any of mem/pad/total flags is set)
//   mem_dout               : memory word, valid the cycle after in_mem_rd_en
//   out_wr_en/out_data     : word write strobe and packed word
//   out_word_addr          : word index within the block
//   out_thread_num/blk_op  : tags taken from the block's first dataset
//   out_blk_end            : asserted with the block's last word
//   err                    : sticky protocol error
module blk_assemble
  import blk_assemble_pkg::*;
#(
  parameter int N_THREADS     = -1,
  parameter int N_THREADS_MSB = msb(N_THREADS - 1)
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     in_mem_rd_en,
  input  logic                     in_add0x80pad,
  input  logic                     in_add0pad,
  input  logic                     in_add_total,
  input  logic [2:0]               in_len,
  input  logic [1:0]               in_off,
  input  logic [PROCB_TOTAL_MSB:0] in_total,
  input  logic [N_THREADS_MSB:0]   in_thread_num,
  input  logic [BLK_OP_MSB:0]      in_blk_op,
  input  logic                     in_blk_end,
  input  logic [31:0]              mem_dout,
  output logic                     out_wr_en,
  output logic [31:0]              out_data,
  output logic [3:0]               out_word_addr,
  output logic [N_THREADS_MSB:0]   out_thread_num,
  output logic [BLK_OP_MSB:0]      out_blk_op,
  output logic                     out_blk_end,
  output logic                     err
);

  localparam logic [7:0] BlkBytes = 8'(BLK_BYTES);
  localparam logic [3:0] LastWord = 4'(BLK_WORDS - 1);

  logic in_valid;
  assign in_valid = in_mem_rd_en | in_add0x80pad | in_add0pad | in_add_total;

  // Stage 1: dataset fields, aligned with mem_dout.
  logic                     s1_valid_q;
  ds_kind_t                 s1_kind_q;
  logic [2:0]               s1_len_q;
  logic [1:0]               s1_off_q;
  logic [PROCB_TOTAL_MSB:0] s1_total_q;
  logic [N_THREADS_MSB:0]   s1_thread_q;
  logic [BLK_OP_MSB:0]      s1_op_q;
  logic                     s1_end_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_q  <= 1'b0;
      s1_kind_q   <= '0;
      s1_len_q    <= '0;
      s1_off_q    <= '0;
      s1_total_q  <= '0;
      s1_thread_q <= '0;
      s1_op_q     <= '0;
      s1_end_q    <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_kind_q   <= {in_mem_rd_en, in_add_total, in_add0x80pad, in_add0pad};
        s1_len_q    <= in_len;
        s1_off_q    <= in_off;
        s1_total_q  <= in_total;
        s1_thread_q <= in_thread_num;
        s1_op_q     <= in_blk_op;
        s1_end_q    <= in_blk_end;
      end
    end
  end

  logic [31:0] ext_bytes;

  blk_assemble_byte_extract u_byte_extract (
    .kind_i     (s1_kind_q),
    .len_i      (s1_len_q),
    .off_i      (s1_off_q),
    .total_i    (s1_total_q),
    .mem_dout_i (mem_dout),
    .bytes_o    (ext_bytes)
  );

  // Stage 2: accumulator, counters and registered write.
  logic [23:0]              acc_q, acc_d;
  logic [1:0]               acc_cnt_q, acc_cnt_d;
  logic [6:0]               cnt_q, cnt_d;
  logic [3:0]               addr_q, addr_d;
  logic                     wr_q, wr_d;
  logic [31:0]              data_q, data_d;
  logic                     end_q, end_d;
  logic [N_THREADS_MSB:0]   thr_q, thr_d;
  logic [BLK_OP_MSB:0]      op_q, op_d;
  logic                     err_q, err_d;

  logic [55:0] merged;
  logic [3:0]  fill;
  logic [7:0]  sum;
  logic [3:0]  mem_span;
  logic        ds_err;

  always_comb begin
    merged   = {32'b0, acc_q} | ({24'b0, ext_bytes} << {acc_cnt_q, 3'b000});
    fill     = {2'b0, acc_cnt_q} + {1'b0, s1_len_q};
    sum      = {1'b0, cnt_q} + {5'b0, s1_len_q};
    mem_span = {2'b0, s1_off_q} + {1'b0, s1_len_q};

    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_d      = 1'b0;
    data_d    = data_q;
    end_d     = 1'b0;
    thr_d     = thr_q;
    op_d      = op_q;
    err_d     = err_q;
    ds_err    = 1'b0;

    if (s1_valid_q) begin
      // First dataset of a block sets the tags used for all its words.
      if (cnt_q == '0) begin
        thr_d = s1_thread_q;
        op_d  = s1_op_q;
      end

      wr_d = (fill >= 4'd4);
      if (wr_d) begin
        data_d    = merged[31:0];
        acc_d     = merged[55:32];
        acc_cnt_d = 2'(fill - 4'd4);
        addr_d    = addr_q + 4'd1;
      end else begin
        acc_d     = merged[23:0];
        acc_cnt_d = fill[1:0];
      end

      cnt_d = (sum > 8'd127) ? 7'h7f : sum[6:0];
      end_d = wr_d & s1_end_q;

      // Block end always restarts the block, even after a protocol error.
      if (s1_end_q) begin
        cnt_d     = '0;
        acc_d     = '0;
        acc_cnt_d = '0;
        addr_d    = '0;
      end

      if (s1_len_q == 3'd0 || s1_len_q > 3'd4)                 ds_err = 1'b1;
      if (s1_kind_q.mem && mem_span > 4'd4)                    ds_err = 1'b1;
      if (sum > BlkBytes)                                      ds_err = 1'b1;
      if (s1_end_q && sum != BlkBytes)                         ds_err = 1'b1;
      if (wr_d && addr_q == LastWord && !s1_end_q)             ds_err = 1'b1;
      if (multi_src(s1_kind_q))                                ds_err = 1'b1;
      if (cnt_q != '0 && s1_thread_q != thr_q)                 ds_err = 1'b1;

      err_d = err_q | ds_err;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q     <= '0;
      acc_cnt_q <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      data_q    <= '0;
      end_q     <= 1'b0;
      thr_q     <= '0;
      op_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      end_q     <= end_d;
      thr_q     <= thr_d;
      op_q      <= op_d;
      err_q     <= err_d;
    end
  end

  // addr_q has already advanced past the word being written.
  logic [3:0] wr_addr_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_addr_q <= '0;
    end else if (wr_d) begin
      wr_addr_q <= addr_q;
    end
  end

  assign out_wr_en      = wr_q;
  assign out_data       = data_q;
  assign out_word_addr  = wr_addr_q;
  assign out_thread_num = thr_q;
  assign out_blk_op     = op_q;
  assign out_blk_end    = end_q;
  assign err            = err_q;

endmodule

// File: tb/tb_blk_assemble.sv
module tb_blk_assemble;
  import blk_assemble_pkg::*;

  localparam int NT = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        in_mem_rd_en, in_add0x80pad, in_add0pad, in_add_total;
  logic [2:0]  in_len;
  logic [1:0]  in_off;
  logic [15:0] in_total;
  logic [1:0]  in_thread_num;
  logic [1:0]  in_blk_op;
  logic        in_blk_end;
  logic [31:0] mem_dout;
  logic        out_wr_en;
  logic [31:0] out_data;
  logic [3:0]  out_word_addr;
  logic [1:0]  out_thread_num;
  logic [1:0]  out_blk_op;
  logic        out_blk_end;
  logic        err;

  blk_assemble #(.N_THREADS(NT)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .in_mem_rd_en   (in_mem_rd_en),
    .in_add0x80pad  (in_add0x80pad),
    .in_add0pad     (in_add0pad),
    .in_add_total   (in_add_total),
    .in_len         (in_len),
    .in_off         (in_off),
    .in_total       (in_total),
    .in_thread_num  (in_thread_num),
    .in_blk_op      (in_blk_op),
    .in_blk_end     (in_blk_end),
    .mem_dout       (mem_dout),
    .out_wr_en      (out_wr_en),
    .out_data       (out_data),
    .out_word_addr  (out_word_addr),
    .out_thread_num (out_thread_num),
    .out_blk_op     (out_blk_op),
    .out_blk_end    (out_blk_end),
    .err            (err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        mem, tot, p80, p0;
    logic [2:0]  len;
    logic [1:0]  off;
    logic [15:0] total;
    logic [1:0]  thr, op;
    logic        blk_end;
    logic [31:0] mword;
    logic        exp_wr;
    logic        chk_data;
    logic [31:0] exp_data;
    logic [3:0]  exp_addr;
    logic        exp_end;
  } vec_t;

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
    logic [3:0]  addr;
    logic        blk_end;
    logic [1:0]  thr, op;
    int          cyc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic        prev_mem = 1'b0;
  logic [31:0] prev_mword = '0;

  function automatic vec_t mk_idle();
    vec_t v;
    v.mem = 0; v.tot = 0; v.p80 = 0; v.p0 = 0;
    v.len = '0; v.off = '0; v.total = '0; v.thr = '0; v.op = '0;
    v.blk_end = 0; v.mword = '0;
    v.exp_wr = 0; v.chk_data = 1; v.exp_data = '0; v.exp_addr = '0; v.exp_end = 0;
    return v;
  endfunction

  function automatic vec_t mk_mem(logic [2:0] len, logic [1:0] off, logic [31:0] w,
                                  logic [1:0] thr, logic [1:0] op);
    vec_t v;
    v = mk_idle();
    v.mem = 1; v.len = len; v.off = off; v.mword = w; v.thr = thr; v.op = op;
    return v;
  endfunction

  // kind: 0 = 0x80 pad, 1 = zero pad, 2 = length field
  function automatic vec_t mk_pad(int kind, logic [2:0] len, logic [15:0] total,
                                  logic [1:0] thr, logic [1:0] op);
    vec_t v;
    v = mk_idle();
    v.p80 = (kind == 0); v.p0 = (kind == 1); v.tot = (kind == 2);
    v.len = len; v.total = total; v.thr = thr; v.op = op;
    return v;
  endfunction

  function automatic vec_t expw(vec_t vin, logic [31:0] data, logic [3:0] addr, logic last);
    vec_t v;
    v = vin;
    v.exp_wr = 1; v.exp_data = data; v.exp_addr = addr; v.exp_end = last;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sample();
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_write: no write for addr %0d, expected at cycle %0d", e.addr, e.cyc);
    end
    if (out_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write (cycle %0d)",
                 out_word_addr, out_data, cyc);
      end else begin
        e = sb.pop_front();
        check("wr_cycle", 32'(cyc), 32'(e.cyc));
        check("wr_addr", {28'b0, out_word_addr}, {28'b0, e.addr});
        if (e.chk_data) begin
          check("wr_data", out_data, e.data);
          check("wr_blk_end", {31'b0, out_blk_end}, {31'b0, e.blk_end});
          check("wr_thread", {30'b0, out_thread_num}, {30'b0, e.thr});
          check("wr_blk_op", {30'b0, out_blk_op}, {30'b0, e.op});
        end
      end
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    in_mem_rd_en  = v.mem;
    in_add_total  = v.tot;
    in_add0x80pad = v.p80;
    in_add0pad    = v.p0;
    in_len        = v.len;
    in_off        = v.off;
    in_total      = v.total;
    in_thread_num = v.thr;
    in_blk_op     = v.op;
    in_blk_end    = v.blk_end;
    // Noise on mem_dout when no read is outstanding.
    mem_dout      = prev_mem ? prev_mword : $urandom();
    prev_mem      = v.mem;
    prev_mword    = v.mword;
    if (v.exp_wr) begin
      e.chk_data = v.chk_data;
      e.data     = v.exp_data;
      e.addr     = v.exp_addr;
      e.blk_end  = v.exp_end;
      e.thr      = v.thr;
      e.op       = v.op;
      e.cyc      = cyc + 2;
      sb.push_back(e);
    end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    sample();
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) step(vecs[i]);
    for (int i = 0; i < 3; i++) step(mk_idle());
    check("sb_drained", 32'(sb.size()), 32'd0);
    vecs.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},  {31'b0, out_wr_en}, 32'd0);
    check({tag, "_data"},   out_data, 32'd0);
    check({tag, "_addr"},   {28'b0, out_word_addr}, 32'd0);
    check({tag, "_thread"}, {30'b0, out_thread_num}, 32'd0);
    check({tag, "_blk_op"}, {30'b0, out_blk_op}, 32'd0);
    check({tag, "_blk_end"}, {31'b0, out_blk_end}, 32'd0);
    check({tag, "_err"},    {31'b0, err}, 32'd0);
  endtask

  task automatic fill_word_block(input logic [1:0] thr, input logic [1:0] op);
    vec_t v;
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin
      w = 32'h0302_0100 + 32'h0404_0404 * i;
      v = mk_mem(3'd4, 2'd0, w, thr, op);
      v.blk_end = (i == 15);
      vecs.push_back(expw(v, w, 4'(i), i == 15));
    end
  endtask

  initial begin
    vec_t v;
    step_inputs_idle();
    #12;
    check_all_zero("reset");
    @(negedge CLK);
    RST_N = 1'b1;
    step(mk_idle());
    step(mk_idle());

    // Aligned full words.
    fill_word_block(2'd1, 2'd2);
    run_vecs();
    check("err_after_words", {31'b0, err}, 32'd0);

    // Single bytes from offset 3, four per word.
    for (int i = 0; i < 64; i++) begin
      v = mk_mem(3'd1, 2'd3, 32'hAA00_0000, 2'd2, 2'd1);
      v.blk_end = (i == 63);
      if (i % 4 == 3) v = expw(v, 32'hAAAA_AAAA, 4'(i / 4), i == 63);
      vecs.push_back(v);
    end
    run_vecs();
    check("err_after_bytes", {31'b0, err}, 32'd0);

    // Message tail "abc" plus padding and length field.
    vecs.push_back(mk_mem(3'd3, 2'd1, 32'h6362_6100, 2'd3, 2'd0));
    vecs.push_back(expw(mk_pad(0, 3'd1, 16'd0, 2'd3, 2'd0), 32'h8063_6261, 4'd0, 1'b0));
    for (int i = 0; i < 13; i++)
      vecs.push_back(expw(mk_pad(1, 3'd4, 16'd0, 2'd3, 2'd0), 32'h0, 4'(i + 1), 1'b0));
    vecs.push_back(expw(mk_pad(2, 3'd4, 16'd3, 2'd3, 2'd0), 32'h0000_0018, 4'd14, 1'b0));
    v = expw(mk_pad(1, 3'd4, 16'd0, 2'd3, 2'd0), 32'h0, 4'd15, 1'b1);
    v.blk_end = 1'b1;
    vecs.push_back(v);
    run_vecs();
    check("err_after_tail", {31'b0, err}, 32'd0);

    // Block end at byte 60: error, then the next block restarts at word 0.
    for (int i = 0; i < 15; i++) begin
      v = mk_mem(3'd4, 2'd0, 32'h1111_1111 * (i + 1), 2'd0, 2'd1);
      v.blk_end = (i == 14);
      v = expw(v, 32'h0, 4'(i), 1'b0);
      v.chk_data = 1'b0;
      vecs.push_back(v);
    end
    run_vecs();
    check("err_short_block", {31'b0, err}, 32'd1);
    fill_word_block(2'd3, 2'd3);
    run_vecs();
    check("err_sticky", {31'b0, err}, 32'd1);

    // Reset after 6 words of a block.
    for (int i = 0; i < 6; i++)
      vecs.push_back(expw(mk_mem(3'd4, 2'd0, 32'hC0DE_0000 + i, 2'd2, 2'd2),
                          32'hC0DE_0000 + i, 4'(i), 1'b0));
    run_vecs();
    RST_N = 1'b0;
    #1;
    check_all_zero("midreset");
    step(mk_idle());
    step(mk_idle());
    check_all_zero("midreset_hold");
    RST_N = 1'b1;
    step(mk_idle());
    fill_word_block(2'd0, 2'd1);
    run_vecs();
    check("err_after_reset", {31'b0, err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic step_inputs_idle();
    in_mem_rd_en  = 0;
    in_add_total  = 0;
    in_add0x80pad = 0;
    in_add0pad    = 0;
    in_len        = '0;
    in_off        = '0;
    in_total      = '0;
    in_thread_num = '0;
    in_blk_op     = '0;
    in_blk_end    = 0;
    mem_dout      = '0;
  endtask

endmodule
